// File: rtl/dict_loader_pkg.sv
// Shared definitions for the dictionary loader: FSM states and ROM image geometry.
// The ROM image generator script reads the same geometry and checksum width.
package dict_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Width of the per-field checksum word stored after the entries
    localparam int CHECKSUM_WIDTH = 16;

    function automatic int entries(input int key_width);
        return 1 << key_width;
    endfunction

    // Each field occupies its entries plus one checksum word
    function automatic int field_stride(input int key_width);
        return entries(key_width) + 1;
    endfunction

endpackage

// File: rtl/dictionary_loader.sv
// Streams every field dictionary from the preloaded ROM into the per-field write
// ports at startup and verifies each field against its stored checksum word.
module dictionary_loader
    import dict_loader_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int KEY_WIDTH  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_FIELDS-1:0] err_mask,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [NUM_FIELDS-1:0] dict_we,
    output logic [DATA_WIDTH-1:0] dict_wdata
);

    localparam int ENTRIES = entries(KEY_WIDTH);
    localparam int STRIDE  = field_stride(KEY_WIDTH);
    localparam int CNT_W   = KEY_WIDTH + 1;
    localparam int FIELD_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam longint IMAGE_END = longint'(BASE_ADDR) + longint'(NUM_FIELDS) * longint'(STRIDE);

    if (IMAGE_END > (longint'(1) << ADDR_WIDTH)) begin : g_image_too_big
        $error("dictionary_loader: ROM image does not fit in ADDR_WIDTH address space");
    end

    state_t                  state_q, state_d;
    logic [FIELD_W-1:0]      field_q, field_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [NUM_FIELDS-1:0]   err_mask_q, err_mask_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            field_q    <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            err_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            err_mask_q <= err_mask_d;
        end
    end

    // Accumulator is cleared in PRIME before every field, so it needs no reset
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign err_mask = err_mask_q;

    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        err_mask_d = err_mask_q;
        acc_d      = acc_q;
        busy       = 1'b0;
        done       = 1'b0;
        rom_en     = 1'b0;
        rom_addr   = '0;
        dict_we    = '0;
        dict_wdata = rom_data;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    err_mask_d = '0;
                    field_d    = '0;
                    cnt_d      = '0;
                    base_d     = ADDR_WIDTH'(BASE_ADDR);
                    state_d    = ST_PRIME;
                end
            end
            ST_PRIME: begin
                busy     = 1'b1;
                rom_en   = 1'b1;
                rom_addr = base_q;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                busy = 1'b1;
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    dict_we[f] = (field_q == FIELD_W'(f));
                end
                acc_d = acc_q + rom_data;
                // Fetch one word ahead; the last fetch lands on the checksum word
                rom_en   = 1'b1;
                rom_addr = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ENTRIES - 1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (acc_q != rom_data) begin
                    for (int f = 0; f < NUM_FIELDS; f++) begin
                        if (field_q == FIELD_W'(f)) begin
                            err_mask_d[f] = 1'b1;
                        end
                    end
                end
                if (field_q != FIELD_W'(NUM_FIELDS - 1)) begin
                    field_d = field_q + FIELD_W'(1);
                    cnt_d   = '0;
                    base_d  = base_q + ADDR_WIDTH'(STRIDE);
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
